// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Adder/subtractor built from 4-bit carry-lookahead groups. Group k is
//   resolved in pipeline stage k, and its carry is registered into stage
//   k+1. Operand bits that are not yet processed travel forward in skew
//   registers that shrink by one nibble per stage. Completed sum bits
//   travel forward in skew registers that grow by one nibble per stage.
//   Latency is STAGES cycles and throughput is one operation per cycle.
//   The pipeline uses a single global stall driven by output backpressure.
//
// Parameters
//   WIDTH     operand width; a multiple of 4, minimum 4
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand set presented
//   in_ready  operand set accepted this cycle (= ~stall)
//   a, b      operands
//   cin       carry-in (ignored when sub=1)
//   sub       0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid result valid
//   out_ready consumer accepts result
//   sum       result modulo 2^WIDTH
//   cout      carry-out (no-borrow when sub=1)
//   ovf       two's-complement overflow

module pipelined_cla_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / 4;

    logic stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unprocessed when entering this stage.
        localparam int RW = WIDTH - 4 * k;

        logic [RW-1:0]    op_a;
        logic [RW-1:0]    op_b;
        logic             cin_k;
        logic             vin_k;
        logic [3:0]       g;
        logic [3:0]       p;
        logic [4:0]       c;
        logic [4*k+3:0]   s_d;

        logic             v_q;
        logic             c_q;
        logic [4*k+3:0]   s_q;

        // Lookahead on the low nibble of whatever operand bits remain.
        always_comb begin
            g    = op_a[3:0] & op_b[3:0];
            p    = op_a[3:0] ^ op_b[3:0];
            c[0] = cin_k;
            c[1] = g[0] | (p[0] & cin_k);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_k);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cin_k);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & cin_k);
        end

        if (k == 0) begin : g_in
            // Subtraction is folded in here: b inverted and carry-in forced to 1.
            assign op_a  = a;
            assign op_b  = sub ? ~b : b;
            assign cin_k = sub | cin;
            assign vin_k = in_valid;
            assign s_d   = p ^ c[3:0];
        end else begin : g_in
            assign op_a  = g_stage[k-1].g_skew.a_q;
            assign op_b  = g_stage[k-1].g_skew.b_q;
            assign cin_k = g_stage[k-1].c_q;
            assign vin_k = g_stage[k-1].v_q;
            assign s_d   = {p ^ c[3:0], g_stage[k-1].s_q};
        end

        // Data registers load only with valid data so the final stage
        // keeps presenting the last result across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (!stall) begin
                v_q <= vin_k;
                if (vin_k) begin
                    c_q <= c[4];
                    s_q <= s_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [RW-5:0] a_q;
            logic [RW-5:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall && vin_k) begin
                    a_q <= op_a[RW-1:4];
                    b_q <= op_b[RW-1:4];
                end
            end
        end

        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (!stall && vin_k) begin
                    ovf_q <= c[3] ^ c[4];
                end
            end
        end
    end

    assign stall     = g_stage[STAGES-1].v_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub
//   Scoreboard bench for pipelined_cla_addsub at WIDTH=16. The driver
//   pushes the expected result of each accepted operation into a queue.
//   The monitor compares the queue head against the outputs every cycle
//   in which out_valid is high, and pops the head when out_ready is high.
//   The monitor also checks latency (STAGES plus the stall cycles),
//   in_ready, and that the outputs hold their values while idle.

module tb_pipelined_cla_addsub;

    localparam int W   = 16;
    localparam int STG = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_cla_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        int unsigned cyc;
        int unsigned stl;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    int unsigned stalls = 0;
    logic [17:0] last_exp = '0;
    logic        was_stall = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge and stall counters. They sample the values from before each edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && !out_ready) stalls <= stalls + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        int          ux, uy, sx, sy, ures, sres;
        logic [31:0] uv;
        logic        co, ov;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        if (sb) begin
            ures = ux - uy;
            sres = sx - sy;
            co   = (ux >= uy);
        end else begin
            ures = ux + uy + int'(ci);
            sres = sx + sy + int'(ci);
            co   = (ures > 65535);
        end
        ov = (sres > 32767) || (sres < -32768);
        uv = ures;
        return {ov, co, uv[15:0]};
    endfunction

    // Presents inputs from just after one edge until just after the next.
    // Acceptance is judged mid-cycle, when in_ready is settled.
    task automatic drive_op(input logic v, input logic [15:0] x, input logic [15:0] y,
                            input logic ci, input logic sb, input logic rdy,
                            input logic [17:0] ex, output logic acc);
        exp_t e;
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = ci;
        sub       = sb;
        out_ready = rdy;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) begin
            e.e_sum  = ex[15:0];
            e.e_cout = ex[16];
            e.e_ovf  = ex[17];
            e.cyc    = cyc;
            e.stl    = stalls;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        logic acc;
        for (int unsigned i = 0; i < n; i++) drive_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
    endtask

    function automatic logic [15:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    mon_e = q[0];
                    chk("result", {14'b0, ovf, cout, sum},
                        {14'b0, mon_e.e_ovf, mon_e.e_cout, mon_e.e_sum});
                    if (!was_stall)
                        chk("latency", cyc, mon_e.cyc + STG + (stalls - mon_e.stl));
                    if (out_ready) begin
                        void'(q.pop_front());
                        last_exp = {mon_e.e_ovf, mon_e.e_cout, mon_e.e_sum};
                    end
                end
            end else begin
                chk("hold_idle", {14'b0, ovf, cout, sum}, {14'b0, last_exp});
            end
            was_stall = out_valid && !out_ready;
        end
    end

    // Driver
    initial begin
        logic          acc;
        logic [15:0]   x, y;
        logic          ci, sb, v, rdy;
        int unsigned   n_acc, guard, issued;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_outputs", {14'b0, ovf, cout, sum}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed corner cases, accepted on the first edge after reset
        drive_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 18'h1_0000, acc);
        chk("first_accept", {31'b0, acc}, 32'd1);
        drive_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 18'h2_8000, acc);
        drive_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 18'h3_7FFF, acc);
        drive_op(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 18'h0_FFFE, acc);
        idle(6);

        // Eight back-to-back operations with backpressure in cycles 5-7
        issued = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            x   = 16'(16'h1111 * i);
            y   = 16'(16'h0F0F + i);
            sb  = i[0];
            rdy = !(i >= 5 && i <= 7);
            drive_op(issued < 8, x, y, 1'b1, sb, rdy, model(x, y, 1'b1, sb), acc);
            if (acc) issued++;
        end
        chk("burst_accepted", issued, 32'd8);
        idle(4);

        // Reset pulse with three operations in flight, one of them at the output
        for (int unsigned i = 0; i < 3; i++) begin
            x = 16'(16'h2345 + i);
            drive_op(1'b1, x, 16'h1357, 1'b0, 1'b0, 1'b1, model(x, 16'h1357, 1'b0, 1'b0), acc);
        end
        drive_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midreset_outputs", {14'b0, ovf, cout, sum}, 32'd0);
        chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        last_exp  = '0;
        was_stall = 1'b0;
        #1 rst_n = 1'b1;
        drive_op(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 18'h0_5556, acc);
        chk("post_reset_accept", {31'b0, acc}, 32'd1);
        idle(8);

        // Random traffic with random valid and ready
        n_acc = 0;
        guard = 0;
        while (n_acc < 10000 && guard < 60000) begin
            x   = rnd_operand();
            y   = rnd_operand();
            ci  = 1'($urandom);
            sb  = 1'($urandom);
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            drive_op(v, x, y, ci, sb, rdy, model(x, y, ci, sb), acc);
            if (acc) n_acc++;
            guard++;
        end
        chk("random_accepted", n_acc, 32'd10000);

        // Drain with a bounded wait
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        chk("drain_empty", q.size(), 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; a multiple of 4 and at least 4.
REQ-002 SHALL have derived constant STAGES = WIDTH/4: the number of 4-bit carry-lookahead groups, which is also the number of pipeline stages.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1 bit: 0 = A+B+cin; 1 = A-B.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port sum, output, WIDTH bits: result.
REQ-014 SHALL have port cout, output, 1 bit: carry-out; when sub=1, 1 means no borrow.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 SHALL compute, when sub=1, A + ~B + 1; when sub=0, A + B + cin.
REQ-017 SHALL take every result modulo 2^WIDTH in sum, with the final carry in cout.
REQ-018 SHALL set ovf = (carry into bit WIDTH-1) XOR cout.
REQ-019 SHALL compute, in each 4-bit group, generate g = a&b and propagate p = a^b (b already conditionally inverted), and derive the group's carries c1..c4 by full lookahead from the group's carry-in, with no ripple inside a group.
REQ-020 SHALL process group k (bits 4k+3..4k) in pipeline stage k, k = 0..STAGES-1.
REQ-021 SHALL register the stage-k group carry-out and feed it as the stage-k+1 carry-in.
REQ-022 SHALL carry the unprocessed upper operand bits and the completed lower sum bits forward in skew registers, so each stage sees only its own group's operands.
REQ-023 SHALL have latency exactly STAGES cycles from an accepted input (in_valid and in_ready at an edge) to out_valid with that result, with no stall in between.
REQ-024 SHALL sustain a throughput of one operation per cycle when out_ready is held 1.
REQ-025 SHALL keep a valid bit in each stage; out_valid is the last stage's valid bit.
REQ-026 SHALL use a global stall: stall = out_valid & ~out_ready, and in_ready = ~stall (combinational).
REQ-027 SHALL, while stall=1, hold every stage register, including all data and valid bits, unchanged; sum, cout and ovf remain stable.
REQ-028 SHALL drop no result and duplicate no result under any in_valid/out_ready pattern.
REQ-029 SHALL let a stage whose valid bit is 0 carry don't-care data, while holding sum/cout/ovf at their last values whenever out_valid=0.
REQ-030 SHALL insert a bubble (valid=0) when an input is not accepted; bubbles advance through the pipeline normally.
REQ-031 SHALL capture the sub input with the operands and use it for the whole flight of that operation; a sub change between operations takes effect per operation.
REQ-032 SHALL, when WIDTH=4 (STAGES=1), have latency 1 and otherwise identical behaviour.

Reset
REQ-033 SHALL, on rst_n low, immediately and asynchronously clear all stage valid bits, so out_valid=0, and clear sum, cout, ovf and all carry/skew registers to 0.
REQ-034 SHALL hold in_ready=1 while rst_n is low and after reset release.
REQ-035 SHALL discard any operations in flight when reset is asserted mid-operation; none appear after release.
REQ-036 SHALL accept operands on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, STAGES=4)
REQ-037 SHALL cover: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-038 SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-039 SHALL cover: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
REQ-040 SHALL cover: 8 back-to-back inputs with out_ready=0 for cycles 5-7 -> in_ready=0 exactly while out_valid & ~out_ready, all 8 results delivered in order, outputs stable during the stall.
REQ-041 SHALL cover: 3 operations in flight, rst_n pulsed low mid-cycle -> out_valid=0 and sum=0 immediately; no stale result after release; a new operation completes 4 cycles after acceptance.
REQ-042 SHALL cover: 10,000 random a/b/cin/sub with random in_valid/out_ready -> every result matches the reference model (sum, cout, ovf) in order.
